wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/wb_arbiter_if.sv | 55 +++++
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_arbiter.sv | 118 +++++++++++
 tb/tb_wb_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter slice.
package wb_arbiter_pkg;

    localparam int REG_W    = 32;
    localparam int REGNUM_W = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REGNUM_W-1:0] rd;
        logic [REG_W-1:0]    data;
    } wb_entry;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result, reservation, hazard and regfile-write signals around the arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                alu_valid;
    logic [REGNUM_W-1:0] alu_rd;
    logic [REG_W-1:0]    alu_data;
    logic                ld_valid;
    logic [REGNUM_W-1:0] ld_rd;
    logic [REG_W-1:0]    ld_data;
    logic                ld_ready;
    logic                md_valid;
    logic [REGNUM_W-1:0] md_rd;
    logic [REG_W-1:0]    md_data;
    logic                md_ready;
    logic                mark_valid;
    logic [REGNUM_W-1:0] mark_rd;
    logic [REGNUM_W-1:0] rs_num;
    logic [REGNUM_W-1:0] rt_num;
    logic                rs_busy;
    logic                rt_busy;
    logic [REGNUM_W-1:0] rd_num;
    logic [REG_W-1:0]    rd_data;
    logic                rd_we;
    logic                halted;
    logic                drain_done;
    logic                waw_err;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  md_valid, md_rd, md_data,
        output md_ready,
        input  mark_valid, mark_rd, rs_num, rt_num,
        output rs_busy, rt_busy,
        output rd_num, rd_data, rd_we,
        input  halted,
        output drain_done, waw_err
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output md_valid, md_rd, md_data,
        input  md_ready,
        output mark_valid, mark_rd, rs_num, rt_num,
        input  rs_busy, rt_busy,
        input  rd_num, rd_data, rd_we,
        output halted,
        input  drain_done, waw_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Deferred-result queue: up to two pushes (a before b) and one pop per cycle.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   push_a,
    input  wb_entry                entry_a,
    input  logic                   push_b,
    input  wb_entry                entry_b,
    input  logic                   pop,
    output wb_entry                head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_b;
    logic [CW-1:0] n_push;

    // b lands behind a when both push, otherwise in a's slot
    assign wr_ptr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;
    assign n_push   = CW'(push_a) + CW'(push_b);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr]   <= entry_a;
        if (push_b) mem[wr_ptr_b] <= entry_b;
    end

    // pointer wrap relies on DEPTH being a power of two
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + n_push - CW'(pop);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, load/mult-div results queue behind them,
// and a busy scoreboard tracks outstanding destination registers.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst_b,
    wb_arbiter_if.slave bus
);

    localparam int            CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_M1 = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_M2 = CW'(FIFO_DEPTH - 2);

    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    wb_entry             head;
    wb_entry             ld_entry;
    wb_entry             md_entry;
    logic                ld_push;
    logic                md_push;
    logic                pop;
    wb_src_e             src;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                rd_we_q;
    logic [REGNUM_W-1:0] rd_num_q;
    logic [REG_W-1:0]    rd_data_q;
    logic                waw_q;
    logic                drain_q;

    assign fifo_empty = (fifo_count == '0);

    // Readies look only at the registered count; mult/div also needs a free
    // slot when no load competes, so the queue can never overfill.
    assign bus.ld_ready = (fifo_count <= CNT_M1);
    assign bus.md_ready = (fifo_count <= CNT_M2) || (!bus.ld_valid && (fifo_count <= CNT_M1));

    // rd==0 results complete the handshake but are dropped here
    assign ld_push  = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);
    assign md_push  = bus.md_valid && bus.md_ready && (bus.md_rd != '0);
    assign ld_entry = '{rd: bus.ld_rd, data: bus.ld_data};
    assign md_entry = '{rd: bus.md_rd, data: bus.md_data};

    always_comb begin
        src = SRC_NONE;
        if (bus.alu_valid && (bus.alu_rd != '0)) src = SRC_ALU;
        else if (!fifo_empty)                    src = SRC_FIFO;
    end

    assign pop = (src == SRC_FIFO);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push_a  (ld_push),
        .entry_a (ld_entry),
        .push_b  (md_push),
        .entry_b (md_entry),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_we_q   <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_we_q <= (src != SRC_NONE);
            unique case (src)
                SRC_ALU: begin
                    rd_num_q  <= bus.alu_rd;
                    rd_data_q <= bus.alu_data;
                end
                SRC_FIFO: begin
                    rd_num_q  <= head.rd;
                    rd_data_q <= head.data;
                end
                default: ;
            endcase
        end
    end

    // set after clear so a same-cycle reservation survives the write
    always_comb begin
        busy_nxt = busy;
        if (rd_we_q) busy_nxt[rd_num_q] = 1'b0;
        if (bus.mark_valid && (bus.mark_rd != '0)) busy_nxt[bus.mark_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy    <= '0;
            waw_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (bus.mark_valid && (bus.mark_rd != '0) && busy[bus.mark_rd]) waw_q <= 1'b1;
            if (!bus.halted)
                drain_q <= 1'b0;
            else if (fifo_empty && (busy == '0) && !bus.alu_valid && !rd_we_q)
                drain_q <= 1'b1;
        end
    end

    assign bus.rs_busy    = busy[bus.rs_num];
    assign bus.rt_busy    = busy[bus.rt_num];
    assign bus.rd_we      = rd_we_q;
    assign bus.rd_num     = rd_num_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.waw_err    = waw_q;
    assign bus.drain_done = drain_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference queue predicts every writeback.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int D = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int      n_cmp = 0;
    int      n_err = 0;
    wr_t     exp_q [$];
    wb_entry mq    [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One clock of stimulus; predicts readiness and the next-cycle write.
    task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
        int      msize;
        logic    ld_ok, md_ok;
        wr_t     e;
        wb_entry h;
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_rd  = lr; bus.ld_data  = ldd;
        bus.md_valid  = mv; bus.md_rd  = mr; bus.md_data  = mdd;
        @(negedge clk);
        msize = mq.size();
        ld_ok = (msize <= D-1);
        md_ok = (msize <= D-2) || (!lv && (msize <= D-1));
        chk("ld_ready", 32'(bus.ld_ready), 32'(ld_ok));
        chk("md_ready", 32'(bus.md_ready), 32'(md_ok));
        chk("fifo_count", 32'(dut.fifo_count), 32'(msize));
        e = '0;
        if (av && ar != 5'd0) begin
            e = '{we: 1'b1, rd: ar, data: ad};
        end else if (msize > 0) begin
            h = mq.pop_front();
            e = '{we: 1'b1, rd: h.rd, data: h.data};
        end
        exp_q.push_back(e);
        if (lv && ld_ok && lr != 5'd0) mq.push_back('{rd: lr, data: ldd});
        if (mv && md_ok && mr != 5'd0) mq.push_back('{rd: mr, data: mdd});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rd_we", 32'(bus.rd_we), 32'(e.we));
            if (e.we) begin
                chk("rd_num", 32'(bus.rd_num), 32'(e.rd));
                chk("rd_data", bus.rd_data, e.data);
            end
        end
        bus.alu_valid  = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.md_valid   = 1'b0;
        bus.mark_valid = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
        bus.md_valid  = 0; bus.md_rd  = 0; bus.md_data  = 0;
        bus.mark_valid = 0; bus.mark_rd = 0;
        bus.rs_num = 0; bus.rt_num = 0; bus.halted = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_we", 32'(bus.rd_we), 32'd0);
        chk("rst_rd_num", 32'(bus.rd_num), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_waw", 32'(bus.waw_err), 32'd0);
        chk("rst_drain", 32'(bus.drain_done), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_count", 32'(dut.fifo_count), 32'd0);
        rst_b = 1'b1;

        // single ALU write, next-cycle visibility
        cyc(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
        chk("alu_we", 32'(bus.rd_we), 32'd1);
        chk("alu_num", 32'(bus.rd_num), 32'd5);
        chk("alu_data", bus.rd_data, 32'h0000_1234);

        // ALU beats a simultaneous load
        cyc(1, 5'd3, 32'h33, 1, 5'd7, 32'hAA, 0, 0, 0);
        chk("pri_alu_num", 32'(bus.rd_num), 32'd3);
        idle();
        chk("pri_ld_num", 32'(bus.rd_num), 32'd7);
        chk("pri_ld_data", bus.rd_data, 32'hAA);

        // fill the queue behind a continuous ALU stream
        for (int i = 0; i < 4; i++)
            cyc(1, 5'(10 + i), 32'h100 + 32'(i), 1, 5'(20 + i), 32'hA0 + 32'(i), 0, 0, 0);
        cyc(1, 5'd14, 32'h114, 1, 5'd24, 32'hBAD, 1, 5'd25, 32'hBAD);
        chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("full_md_ready", 32'(bus.md_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("drain_we", 32'(bus.rd_we), 32'd1);
            chk("drain_order", 32'(bus.rd_num), 32'(20 + i));
        end

        // load is queued ahead of mult/div in the same cycle
        cyc(0, 0, 0, 1, 5'd14, 32'h140, 1, 5'd15, 32'h150);
        idle();
        chk("lm_first", 32'(bus.rd_num), 32'd14);
        idle();
        chk("lm_second", 32'(bus.rd_num), 32'd15);

        // rd==0 load: accepted, discarded
        cyc(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0);
        chk("rd0_count", 32'(dut.fifo_count), 32'd0);
        chk("rd0_we", 32'(bus.rd_we), 32'd0);

        // mixed random traffic against the model
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom(),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom(),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom());
        end
        for (int i = 0; i < 12 && mq.size() > 0; i++) idle();
        idle();

        // reservation, hazard query, WAW and release
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
        idle();
        bus.rs_num = 5'd9; bus.rt_num = 5'd9;
        #1;
        chk("rs_busy_set", 32'(bus.rs_busy), 32'd1);
        chk("rt_busy_set", 32'(bus.rt_busy), 32'd1);
        bus.rt_num = 5'd0;
        #1;
        chk("r0_not_busy", 32'(bus.rt_busy), 32'd0);
        chk("waw_clear", 32'(bus.waw_err), 32'd0);
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
        idle();
        chk("waw_set", 32'(bus.waw_err), 32'd1);
        cyc(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0);
        idle();
        chk("r9_we", 32'(bus.rd_we), 32'd1);
        chk("busy_during_we", 32'(bus.rs_busy), 32'd1);
        idle();
        chk("busy_released", 32'(bus.rs_busy), 32'd0);
        chk("waw_sticky", 32'(bus.waw_err), 32'd1);

        // halted drain of two queued loads
        cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0);
        cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 0);
        bus.halted = 1'b1;
        idle();
        chk("halt_wr1", 32'(bus.rd_num), 32'd2);
        idle();
        chk("halt_wr2", 32'(bus.rd_num), 32'd4);
        idle();
        chk("drain_pending", 32'(bus.drain_done), 32'd0);
        for (int i = 0; i < 4 && bus.drain_done !== 1'b1; i++) idle();
        chk("drain_done", 32'(bus.drain_done), 32'd1);
        bus.halted = 1'b0;
        idle();
        chk("drain_clear", 32'(bus.drain_done), 32'd0);

        // reset in the middle of a halted drain
        bus.halted = 1'b1;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd12;
        cyc(1, 5'd1, 32'h1, 1, 5'd5, 32'h55, 0, 0, 0);
        cyc(1, 5'd2, 32'h2, 1, 5'd6, 32'h66, 0, 0, 0);
        idle();
        chk("mid_wr", 32'(bus.rd_num), 32'd5);
        bus.rs_num = 5'd12;
        rst_b = 1'b0;
        exp_q.delete();
        mq.delete();
        #1;
        chk("mid_rst_we", 32'(bus.rd_we), 32'd0);
        chk("mid_rst_num", 32'(bus.rd_num), 32'd0);
        chk("mid_rst_data", bus.rd_data, 32'd0);
        chk("mid_rst_count", 32'(dut.fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(bus.rs_busy), 32'd0);
        chk("mid_rst_waw", 32'(bus.waw_err), 32'd0);
        chk("mid_rst_drain", 32'(bus.drain_done), 32'd0);
        chk("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("mid_rst_md_ready", 32'(bus.md_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        bus.halted = 1'b0;
        idle();
        chk("post_rst_idle", 32'(bus.rd_we), 32'd0);
        cyc(1, 5'd6, 32'hCAFE, 0, 0, 0, 0, 0, 0);
        chk("post_rst_alu", bus.rd_data, 32'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
